// File: rtl/conv_mac_engine.sv
// Multi-cycle dot-product engine: TAPS element pairs, LANES MACs per cycle, wide wrapping accumulator.
// Optional build macro CONV_MAC_RELU_EN clamps negative results to zero on the result port (signed mode only).
module conv_mac_engine #(
    parameter int ELEM_W = 8,
    parameter int TAPS   = 4,
    parameter int LANES  = 1,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     accumulate,
    input  logic [TAPS*ELEM_W-1:0]   a_vec,
    input  logic [TAPS*ELEM_W-1:0]   b_vec,
    output logic                     busy,
    output logic                     done,
    output logic [ACC_W-1:0]         result,
    output logic                     overflow
);

    localparam int IDX_W = $clog2(TAPS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - LANES);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [TAPS*ELEM_W-1:0]    aLatch_q, aLatch_d;
    logic [TAPS*ELEM_W-1:0]    bLatch_q, bLatch_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic                      ovf_q, ovf_d;

    logic [ELEM_W-1:0]         elemA, elemB;
    logic [ACC_W-1:0]          opA, opB, addend, laneSum;
    logic [ACC_W:0]            sumExt;
    logic                      laneOvf;

    // Operands are widened to ACC_W before multiplying; since ACC_W >= 2*ELEM_W the
    // truncated product equals the sign/zero-extended full product. Lanes add in index order.
    always_comb begin
        laneSum = acc_q;
        laneOvf = ovf_q;
        elemA   = '0;
        elemB   = '0;
        opA     = '0;
        opB     = '0;
        addend  = '0;
        sumExt  = '0;
        for (int k = 0; k < LANES; k++) begin
            elemA  = aLatch_q[(int'(idx_q) + k)*ELEM_W +: ELEM_W];
            elemB  = bLatch_q[(int'(idx_q) + k)*ELEM_W +: ELEM_W];
            opA    = {{(ACC_W-ELEM_W){(SIGNED != 0) && elemA[ELEM_W-1]}}, elemA};
            opB    = {{(ACC_W-ELEM_W){(SIGNED != 0) && elemB[ELEM_W-1]}}, elemB};
            addend = opA * opB;
            sumExt = {1'b0, laneSum} + {1'b0, addend};
            if (SIGNED != 0) begin
                if ((laneSum[ACC_W-1] == addend[ACC_W-1]) &&
                    (sumExt[ACC_W-1] != laneSum[ACC_W-1])) begin
                    laneOvf = 1'b1;
                end
            end else if (sumExt[ACC_W]) begin
                laneOvf = 1'b1;
            end
            laneSum = sumExt[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        aLatch_d = aLatch_q;
        bLatch_d = bLatch_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    aLatch_d = a_vec;
                    bLatch_d = b_vec;
                    idx_d    = '0;
                    if (!accumulate) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = laneSum;
                ovf_d = laneOvf;
                // Index parks at 0 on completion so lane selects never point past the vector.
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_STEP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            aLatch_q <= '0;
            bLatch_q <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            aLatch_q <= aLatch_d;
            bLatch_q <= bLatch_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;

`ifdef CONV_MAC_RELU_EN
    assign result = ((SIGNED != 0) && acc_q[ACC_W-1]) ? '0 : acc_q;
`else
    assign result = acc_q;
`endif

endmodule
